i2f128_issue: RTL and testbench

- Request/response sequencer directly upstream of the 128-bit integer-to-float converter.
- Accepts tagged conversion requests on a valid/ready handshake and drives the converter's ce/op/rm/i inputs.
- Tracks in-flight operations through the converter's fixed latency and captures cvt_o, with tag, into a result FIFO that has its own valid/ready handshake.
- Credit-based issue guarantees no result is lost under backpressure.

---
 rtl/i2f128_issue_pkg.sv | 17 +
 rtl/i2f128_issue_res_fifo.sv | 57 +++++
 rtl/i2f128_issue.sv | 134 +++++++++++++
 tb/tb_i2f128_issue.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2f128_issue_pkg.sv
// Shared constants and the result-FIFO entry type for the i2f128 issue sequencer.
// The floating-point widths mirror the fp128Pkg definitions for binary128.
package i2f128_issue_pkg;

  localparam int unsigned FPWID          = 128;
  localparam int unsigned MSB            = FPWID - 1;
  localparam int unsigned EMSB           = 14;
  localparam int unsigned FMSB           = 111;
  localparam int unsigned I2F_ISSUE_TAGW = 4;

  typedef struct packed {
    logic [FPWID-1:0]          o;
    logic [I2F_ISSUE_TAGW-1:0] tag;
    logic                      inexact;
  } i2f_res_t;

endpackage

// File: rtl/i2f128_issue_res_fifo.sv
// Result buffer: DEPTH-entry circular FIFO of converter results with an occupancy count.
// Head entry is read straight from storage; a write is visible only on the following cycle.
module i2f_res_fifo
  import i2f128_issue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  i2f_res_t                     din_i,
  input  logic                         pop_i,
  output i2f_res_t                     dout_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  i2f_res_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pop_ok;

  assign pop_ok = pop_i & (cnt_q != '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_i);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    cnt_d    = cnt_q + CW'(push_i) - CW'(pop_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_i && (cnt_q == CW'(DEPTH))));

endmodule

// File: rtl/i2f128_issue.sv
// Credit-based request/response sequencer in front of the 128-bit int-to-float converter.
// Define I2F_ISSUE_INEXACT_EN to compute and carry a truncation-loss flag with each result.
module i2f128_issue #(
  parameter int unsigned FPWID   = i2f128_issue_pkg::FPWID,
  parameter int unsigned TAGW    = i2f128_issue_pkg::I2F_ISSUE_TAGW,
  parameter int unsigned CVT_LAT = 1,
  parameter int unsigned DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [2:0]       req_rm,
  input  logic [FPWID-1:0] req_i,
  input  logic [TAGW-1:0]  req_tag,
  output logic             cvt_ce,
  output logic             cvt_op,
  output logic [2:0]       cvt_rm,
  output logic [FPWID-1:0] cvt_i,
  input  logic [FPWID-1:0] cvt_o,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [FPWID-1:0] res_o,
  output logic [TAGW-1:0]  res_tag,
  output logic             res_inexact,
  output logic             busy
);
  import i2f128_issue_pkg::*;

  localparam int unsigned CW   = $clog2(DEPTH + 1);
  localparam int unsigned LW   = $clog2(CVT_LAT + 1);
  localparam int unsigned SW   = $clog2(DEPTH + CVT_LAT + 1);
  localparam int unsigned LAST = CVT_LAT - 1;

  logic [CVT_LAT-1:0] vld_q, vld_d;
  logic [CVT_LAT-1:0] inx_q, inx_d;
  logic [TAGW-1:0]    tag_q [CVT_LAT];
  logic [TAGW-1:0]    tag_d [CVT_LAT];
  logic [LW-1:0]      inflight_c;
  logic [SW-1:0]      used_c;
  logic [CW-1:0]      fifo_cnt;
  logic               fire_c, push_c, pop_c, inexact_c;
  i2f_res_t           din_c, head_c;

  always_comb begin
    inflight_c = '0;
    for (int k = 0; k < int'(CVT_LAT); k++) inflight_c = inflight_c + LW'(vld_q[k]);
  end

  // Every accepted request owns a FIFO slot until it is popped.
  assign used_c    = SW'(fifo_cnt) + SW'(inflight_c);
  assign req_ready = (used_c < SW'(DEPTH)) & ~rst;
  assign fire_c    = req_valid & req_ready;
  assign cvt_ce    = fire_c | (inflight_c != '0);

  assign cvt_op = fire_c & req_op;
  assign cvt_rm = fire_c ? req_rm : 3'd0;
  assign cvt_i  = fire_c ? req_i  : '0;

`ifdef I2F_ISSUE_INEXACT_EN
  logic [FPWID-1:0] mag_c;
  int               lead_c, trail_c;

  // More significant bits than the binary128 significand can hold means precision is lost.
  always_comb begin
    mag_c   = (req_op & req_i[FPWID-1]) ? -req_i : req_i;
    lead_c  = 0;
    trail_c = 0;
    for (int k = 0; k < int'(FPWID); k++) if (mag_c[k]) lead_c = k;
    for (int k = int'(FPWID) - 1; k >= 0; k--) if (mag_c[k]) trail_c = k;
    inexact_c = (mag_c != '0) && ((lead_c - trail_c) > (int'(FMSB) + 1));
  end
`else
  assign inexact_c = 1'b0;
`endif

  // Tracking pipe mirrors the converter: it only moves when the converter is enabled.
  always_comb begin
    vld_d = vld_q;
    inx_d = inx_q;
    tag_d = tag_q;
    if (cvt_ce) begin
      vld_d[0] = fire_c;
      inx_d[0] = inexact_c;
      tag_d[0] = req_tag;
      for (int k = 1; k < int'(CVT_LAT); k++) begin
        vld_d[k] = vld_q[k-1];
        inx_d[k] = inx_q[k-1];
        tag_d[k] = tag_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      inx_q <= '0;
      for (int k = 0; k < int'(CVT_LAT); k++) tag_q[k] <= '0;
    end else begin
      vld_q <= vld_d;
      inx_q <= inx_d;
      tag_q <= tag_d;
    end
  end

  assign push_c = cvt_ce & vld_q[LAST];
  assign pop_c  = res_valid & res_ready;

  always_comb begin
    din_c         = '0;
    din_c.o       = cvt_o;
    din_c.tag     = tag_q[LAST];
    din_c.inexact = inx_q[LAST];
  end

  i2f_res_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_c),
    .din_i   (din_c),
    .pop_i   (pop_c),
    .dout_o  (head_c),
    .count_o (fifo_cnt)
  );

  // Head fields are masked while empty so stale storage never leaks out.
  assign res_valid   = (fifo_cnt != '0);
  assign res_o       = res_valid ? head_c.o : '0;
  assign res_tag     = res_valid ? head_c.tag : '0;
  assign res_inexact = res_valid & head_c.inexact;
  assign busy        = (inflight_c != '0) | res_valid;

endmodule

// File: tb/tb_i2f128_issue.sv
// Self-checking bench for i2f128_issue with a transaction-level model and a stand-in converter.
module tb_i2f128_issue;

  localparam int DEPTH = 4;
`ifdef I2F_ISSUE_INEXACT_EN
  localparam bit INX_EN = 1'b1;
`else
  localparam bit INX_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0, req_op = 1'b0, res_ready = 1'b0;
  logic [2:0]   req_rm = 3'd0;
  logic [127:0] req_i = '0;
  logic [3:0]   req_tag = '0;
  logic         req_ready, cvt_ce, cvt_op, res_valid, res_inexact, busy;
  logic [2:0]   cvt_rm;
  logic [127:0] cvt_i, cvt_o, res_o;
  logic [3:0]   res_tag;

  i2f128_issue dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rm(req_rm), .req_i(req_i), .req_tag(req_tag), .cvt_ce(cvt_ce), .cvt_op(cvt_op),
    .cvt_rm(cvt_rm), .cvt_i(cvt_i), .cvt_o(cvt_o), .res_valid(res_valid), .res_ready(res_ready),
    .res_o(res_o), .res_tag(res_tag), .res_inexact(res_inexact), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] o;
    logic [3:0]   tag;
    logic         inx;
    int           avail;
  } item_t;

  item_t q[$];
  int total = 0, bad = 0, cyc = 0, nobs = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Stand-in converter: binary128 from integer, truncating the fraction.
  function automatic logic [127:0] conv(input logic op, input logic [127:0] i);
    logic sgn;
    logic [127:0] m, mn;
    int p;
    if (i == 0) return '0;
    sgn = op & i[127];
    m = sgn ? -i : i;
    p = 0;
    for (int k = 0; k < 128; k++) if (m[k]) p = k;
    mn = m << (127 - p);
    return {sgn, 15'(16383 + p), mn[126:15]};
  endfunction

  function automatic int sigbits(input logic op, input logic [127:0] i);
    logic [127:0] m;
    int hi, lo;
    m = (op & i[127]) ? -i : i;
    if (m == 0) return 0;
    hi = 0; lo = 0;
    for (int k = 0; k < 128; k++) if (m[k]) hi = k;
    for (int k = 127; k >= 0; k--) if (m[k]) lo = k;
    return hi - lo + 1;
  endfunction

  function automatic logic inx_model(input logic op, input logic [127:0] i);
    return INX_EN && (sigbits(op, i) > 113);
  endfunction

  logic [127:0] cvt_q = '0;
  assign cvt_o = cvt_q;
  always @(posedge clk) if (cvt_ce) cvt_q <= conv(cvt_op, cvt_i);
  always @(posedge clk) cyc <= cyc + 1;

  // Model: an accepted request holds a credit until popped and appears two cycles after acceptance.
  always @(negedge clk) begin : cmp
    item_t it;
    logic exp_rr, exp_rv, exp_fire, exp_ce;
    int infl;
    if (res_valid && res_ready) nobs++;
    if (rst) begin
      q.delete();
      chk("rst_req_ready", 128'(req_ready), 128'(0));
      chk("rst_res_valid", 128'(res_valid), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_cvt_ce", 128'(cvt_ce), 128'(0));
      chk("rst_res_o", res_o, 128'(0));
      chk("rst_res_tag", 128'(res_tag), 128'(0));
      chk("rst_res_inexact", 128'(res_inexact), 128'(0));
    end else begin
      infl = 0;
      foreach (q[k]) if (q[k].avail > cyc) infl++;
      exp_rr   = (q.size() < DEPTH);
      exp_rv   = (q.size() > 0) && (q[0].avail <= cyc);
      exp_fire = req_valid && exp_rr;
      exp_ce   = exp_fire || (infl > 0);
      chk("req_ready", 128'(req_ready), 128'(exp_rr));
      chk("res_valid", 128'(res_valid), 128'(exp_rv));
      chk("busy", 128'(busy), 128'(q.size() > 0));
      chk("cvt_ce", 128'(cvt_ce), 128'(exp_ce));
      chk("cvt_i", cvt_i, exp_fire ? req_i : 128'(0));
      chk("cvt_op", 128'(cvt_op), 128'(exp_fire & req_op));
      chk("cvt_rm", 128'(cvt_rm), exp_fire ? 128'(req_rm) : 128'(0));
      if (exp_rv) begin
        chk("res_o", res_o, q[0].o);
        chk("res_tag", 128'(res_tag), 128'(q[0].tag));
        chk("res_inexact", 128'(res_inexact), 128'(q[0].inx));
        if (res_ready) void'(q.pop_front());
      end
      if (exp_fire) begin
        it.o = conv(req_op, req_i);
        it.tag = req_tag;
        it.inx = inx_model(req_op, req_i);
        it.avail = cyc + 2;
        q.push_back(it);
      end
    end
  end

  task automatic drive(input logic v, input logic op, input logic [2:0] rm,
                       input logic [127:0] i, input logic [3:0] tag, input logic rr,
                       output logic acc);
    req_valid = v; req_op = op; req_rm = rm; req_i = i; req_tag = tag; res_ready = rr;
    @(negedge clk);
    acc = v & req_ready;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input logic rr);
    logic a;
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 3'd0, '0, '0, rr, a);
  endtask

  task automatic wait_rv(input string nm);
    bit ok;
    ok = 0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (res_valid) ok = 1;
      else begin @(posedge clk); #1; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL %s: timeout waiting for res_valid", nm);
    end
  endtask

  function automatic logic [127:0] rnd128();
    logic [127:0] v;
    v = {$urandom, $urandom, $urandom, $urandom};
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 128'(1) << $urandom_range(0, 127);
      default: return v >> $urandom_range(0, 127);
    endcase
  endfunction

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    logic a;
    int acc, n0, k;
    logic [127:0] big;

    chk("model_conv_one", conv(1'b0, 128'd1), 128'h3FFF0000_00000000_00000000_00000000);
    chk("model_conv_m1", conv(1'b1, '1), 128'hBFFF0000_00000000_00000000_00000000);
    chk("model_conv_minneg", conv(1'b1, 128'h80000000_00000000_00000000_00000000),
        128'hC07E0000_00000000_00000000_00000000);
    chk("model_conv_zero", conv(1'b0, '0), 128'h0);
    chk("model_sig_big", 128'(sigbits(1'b0, 128'h80000000_00000000_00000000_00000001)), 128'd128);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 128'(res_valid), 128'(0));
    @(posedge clk); #1;

    // Unsigned 1, tag 3: not visible one cycle later, visible two cycles later.
    drive(1'b1, 1'b0, 3'd0, 128'd1, 4'd3, 1'b1, a);
    chk("one_accept", 128'(a), 128'(1));
    req_valid = 1'b0;
    @(negedge clk);
    chk("one_lat_early", 128'(res_valid), 128'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("one_lat", 128'(res_valid), 128'(1));
    chk("one_res_o", res_o, 128'h3FFF0000_00000000_00000000_00000000);
    chk("one_tag", 128'(res_tag), 128'd3);
    chk("one_inx", 128'(res_inexact), 128'd0);
    @(posedge clk); #1;
    idle(2, 1'b1);

    // Signed -1 then zero, back to back.
    drive(1'b1, 1'b1, 3'd2, '1, 4'd5, 1'b1, a);
    drive(1'b1, 1'b0, 3'd0, '0, 4'd6, 1'b1, a);
    req_valid = 1'b0;
    wait_rv("m1_wait");
    chk("m1_res_o", res_o, 128'hBFFF0000_00000000_00000000_00000000);
    chk("m1_tag", 128'(res_tag), 128'd5);
    @(posedge clk); #1;
    @(negedge clk);
    chk("zero_valid", 128'(res_valid), 128'd1);
    chk("zero_res_o", res_o, 128'h0);
    chk("zero_tag", 128'(res_tag), 128'd6);
    @(posedge clk); #1;
    idle(3, 1'b1);

    // Backpressure: six requests against a stalled consumer.
    n0 = nobs; acc = 0; k = 0;
    for (int n = 0; n < 6; n++) begin
      drive(1'b1, 1'b0, 3'd0, 128'(100 + k), 4'(k), 1'b0, a);
      if (a) begin acc++; k++; end
    end
    chk("bp_accepted", 128'(acc), 128'd4);
    @(negedge clk);
    chk("bp_ready_low", 128'(req_ready), 128'd0);
    @(posedge clk); #1;
    for (int n = 0; n < 30 && k < 6; n++) begin
      drive(1'b1, 1'b0, 3'd0, 128'(100 + k), 4'(k), 1'b1, a);
      if (a) k++;
    end
    chk("bp_all_accepted", 128'(k), 128'd6);
    idle(8, 1'b1);
    chk("bp_results", 128'(nobs - n0), 128'd6);

    // Fill to full, then stream 3*DEPTH cycles with push and pop together.
    n0 = nobs; acc = 0;
    for (int n = 0; n < 6; n++) begin
      drive(1'b1, 1'b1, 3'd1, rnd128(), 4'(n), 1'b0, a);
      if (a) acc++;
    end
    for (int n = 0; n < 3 * DEPTH; n++) begin
      drive(1'b1, 1'b1, 3'(n), rnd128(), 4'(n + 4), 1'b1, a);
      if (a) acc++;
    end
    chk("stream_accepted", 128'(acc), 128'(DEPTH + 3 * DEPTH - 1));
    idle(8, 1'b1);
    chk("stream_no_loss", 128'(nobs - n0), 128'(acc));

    // Reset with one in flight and three buffered.
    for (int n = 0; n < 4; n++) drive(1'b1, 1'b0, 3'd0, 128'(7 + n), 4'(9 + n), 1'b0, a);
    req_valid = 1'b0;
    chk("pre_rst_valid", 128'(res_valid), 128'd1);
    chk("pre_rst_busy", 128'(busy), 128'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 128'(res_valid), 128'd0);
    chk("mid_rst_busy", 128'(busy), 128'd0);
    chk("mid_rst_ready", 128'(req_ready), 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    n0 = nobs;
    idle(6, 1'b1);
    chk("no_stale_after_rst", 128'(nobs - n0), 128'd0);

    // Truncation flag boundary values.
    big = 128'h80000000_00000000_00000000_00000001;
    drive(1'b1, 1'b0, 3'd0, big, 4'd7, 1'b1, a);
    req_valid = 1'b0;
    wait_rv("inx1_wait");
    chk("inx_2p127p1", 128'(res_inexact), 128'(INX_EN));
    chk("inx_2p127p1_tag", 128'(res_tag), 128'd7);
    @(posedge clk); #1;
    idle(2, 1'b1);
    big = 128'h80000000_00000000_00000000_00000000;
    drive(1'b1, 1'b0, 3'd0, big, 4'd8, 1'b1, a);
    req_valid = 1'b0;
    wait_rv("inx0_wait");
    chk("inx_2p127", 128'(res_inexact), 128'd0);
    chk("inx_2p127_res_o", res_o, 128'h407E0000_00000000_00000000_00000000);
    @(posedge clk); #1;
    idle(2, 1'b1);

    // Randomized traffic with random consumer backpressure.
    for (int n = 0; n < 400; n++)
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 3'($urandom), rnd128(),
            4'($urandom), 1'($urandom_range(0, 2) != 0), a);
    idle(10, 1'b1);
    @(negedge clk);
    chk("final_idle", 128'(busy), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
